// File: rtl/fpu_float_to_int_unit.sv
// Pipelined IEEE-754 single to signed int32 converter (round-to-nearest-even), fixed latency.
// Define FTI_FLAGS_EN to add the {invalid, overflow} result sideband on m_axis_result_tuser.
module fpu_float_to_int_unit #(
  parameter int unsigned LATENCY = 3  // legal 2..6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  output logic        m_axis_result_tvalid,
`ifdef FTI_FLAGS_EN
  output logic [1:0]  m_axis_result_tuser,
`endif
  output logic [31:0] m_axis_result_tdata
);

  localparam int NumOut = int'(LATENCY) - 1;

  // Stage 1: unpack, classify, align.
  logic               sign;
  logic [7:0]         exp_b;
  logic [22:0]        frac;
  logic [23:0]        mant;
  logic signed [8:0]  unb;
  logic               is_nan, is_min, is_ovf, is_tiny;
  logic [4:0]         shr_amt;
  logic [2:0]         shl_amt;
  logic [48:0]        shr;
  logic [31:0]        int_d;
  logic               guard_d, sticky_d;

  always_comb begin
    sign     = s_axis_a_tdata[31];
    exp_b    = s_axis_a_tdata[30:23];
    frac     = s_axis_a_tdata[22:0];
    mant     = (exp_b != 8'd0) ? {1'b1, frac} : 24'd0;
    unb      = $signed({1'b0, exp_b}) - 9'sd127;
    is_nan   = (exp_b == 8'hff) && (frac != 23'd0);
    // -2^31 is representable even though its exponent lands in the overflow class
    is_min   = sign && (exp_b == 8'd158) && (frac == 23'd0);
    is_ovf   = (unb >= 9'sd31) && !is_nan && !is_min;
    is_tiny  = (unb < -9'sd1);
    shr_amt  = 5'(9'sd23 - unb);
    shl_amt  = 3'(unb - 9'sd23);
    shr      = {mant, 25'd0} >> shr_amt;
    int_d    = 32'd0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (!is_tiny && (unb <= 9'sd23)) begin
      int_d    = {8'd0, shr[48:25]};
      guard_d  = shr[24];
      sticky_d = |shr[23:0];
    end else if ((unb >= 9'sd24) && (unb <= 9'sd30)) begin
      int_d = {8'd0, mant} << shl_amt;
    end
  end

  logic        s1_valid_q, s1_sign_q, s1_guard_q, s1_sticky_q, s1_nan_q, s1_ovf_q, s1_min_q;
  logic [31:0] s1_int_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_ovf_q    <= 1'b0;
      s1_min_q    <= 1'b0;
      s1_int_q    <= 32'd0;
    end else begin
      s1_valid_q <= s_axis_a_tvalid;
      if (s_axis_a_tvalid) begin
        s1_sign_q   <= sign;
        s1_guard_q  <= guard_d;
        s1_sticky_q <= sticky_d;
        s1_nan_q    <= is_nan;
        s1_ovf_q    <= is_ovf;
        s1_min_q    <= is_min;
        s1_int_q    <= int_d;
      end
    end
  end

  // Stage 2: round, apply sign, saturate.
  logic        round_up;
  logic [31:0] mag;
  logic [31:0] data_d;

  always_comb begin
    round_up = s1_guard_q & (s1_sticky_q | s1_int_q[0]);
    mag      = s1_int_q + {31'd0, round_up};
    if (s1_nan_q || s1_min_q) begin
      data_d = 32'h8000_0000;
    end else if (s1_ovf_q) begin
      data_d = s1_sign_q ? 32'h8000_0000 : 32'h7fff_ffff;
    end else if (!s1_sign_q && mag[31]) begin
      data_d = 32'h7fff_ffff;
    end else begin
      data_d = s1_sign_q ? (32'd0 - mag) : mag;
    end
  end

`ifdef FTI_FLAGS_EN
  logic [1:0] flags_d;
  always_comb begin
    flags_d = {s1_nan_q, s1_ovf_q | (!s1_nan_q && !s1_min_q && !s1_sign_q && mag[31])};
  end
`endif

  // Entry 0 is the stage-2 result register; later entries are pure delay.
  logic [NumOut-1:0] pipe_valid_q;
  logic [31:0]       pipe_data_q [NumOut];
`ifdef FTI_FLAGS_EN
  logic [1:0]        pipe_flags_q [NumOut];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      for (int k = 0; k < NumOut; k++) begin
        pipe_data_q[k] <= 32'd0;
`ifdef FTI_FLAGS_EN
        pipe_flags_q[k] <= 2'd0;
`endif
      end
    end else begin
      pipe_valid_q[0] <= s1_valid_q;
      if (s1_valid_q) begin
        pipe_data_q[0] <= data_d;
`ifdef FTI_FLAGS_EN
        pipe_flags_q[0] <= flags_d;
`endif
      end
      for (int k = 1; k < NumOut; k++) begin
        pipe_valid_q[k] <= pipe_valid_q[k-1];
        if (pipe_valid_q[k-1]) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
`ifdef FTI_FLAGS_EN
          pipe_flags_q[k] <= pipe_flags_q[k-1];
`endif
        end
      end
    end
  end

  assign m_axis_result_tvalid = pipe_valid_q[NumOut-1];
  assign m_axis_result_tdata  = pipe_data_q[NumOut-1];
`ifdef FTI_FLAGS_EN
  assign m_axis_result_tuser  = pipe_flags_q[NumOut-1];
`endif

endmodule
